// File: rtl/kalman_pkg.sv
// Shared EKF matrix-engine definitions: 4x4 matrix packing helpers and scheduler state encoding.
package kalman_pkg;
  localparam int N_DEF     = 32;
  localparam int MAT_ELEMS = 16;

  function automatic int mat_w(input int n);
    return MAT_ELEMS * n;
  endfunction

  localparam int MAT_W = mat_w(N_DEF);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } sched_state_e;

  // Element (r,c) sits at word 4r+c of a packed matrix.
  function automatic int unsigned mat_idx(input int unsigned r, input int unsigned c);
    return 4 * r + c;
  endfunction
endpackage

// File: rtl/matmul_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer, wrapping to 0.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_vld
);
  int w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_vld = 1'b0;
    w_j   = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_j = (int'(i_ptr) + i) % NREQ;
      if (!o_vld && i_req[w_j]) begin
        o_vld      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/matmul_scheduler.sv
// Time-shares one fixed-latency 4x4 multiplier between NREQ requesters in round-robin order.
module matmul_scheduler
  import kalman_pkg::*;
#(
  parameter int N    = 32,
  parameter int Q    = 18,
  parameter int NREQ = 4,
  parameter int LAT  = 18
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*16*N-1:0]   req_a,
  input  logic [NREQ*16*N-1:0]   req_b,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        done,
  output logic [16*N-1:0]        result,
  output logic                   busy,
  output logic [16*N-1:0]        mm_a,
  output logic [16*N-1:0]        mm_b,
  output logic                   mm_rst_n,
  input  logic [16*N-1:0]        mm_result
);
  localparam int MW = mat_w(N);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(LAT) + 1;

  if (NREQ < 2 || NREQ > 8 || LAT < 1 || Q >= N) begin : g_bad_cfg
    $error("matmul_scheduler: unsupported NREQ/LAT/Q");
  end

  sched_state_e    r_state;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_ptr;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] r_done;
  logic [MW-1:0]   r_result;
  logic [MW-1:0]   r_mm_a;
  logic [MW-1:0]   r_mm_b;
  logic            r_mm_rst_n;

  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_idx;
  logic            w_vld;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_vld (w_vld)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_done     <= '0;
      r_result   <= '0;
      r_mm_a     <= '0;
      r_mm_b     <= '0;
      r_mm_rst_n <= 1'b0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: if (w_vld) begin
          r_owner <= w_idx;
          r_mm_a  <= req_a[w_idx*MW +: MW];
          r_mm_b  <= req_b[w_idx*MW +: MW];
          // Pointer moves past the winner so a re-requesting owner queues behind others.
          r_ptr   <= (w_idx == IW'(NREQ-1)) ? '0 : w_idx + 1'b1;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_mm_rst_n <= 1'b1;
          r_cnt      <= '0;
          r_state    <= S_RUN;
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(LAT-1)) begin
            r_result   <= mm_result;
            r_mm_rst_n <= 1'b0;
            r_done     <= {{(NREQ-1){1'b0}}, 1'b1} << r_owner;
            r_state    <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Grant is only offered from IDLE and never while reset is being applied.
  assign grant    = (r_state == S_IDLE && reset) ? w_gnt : '0;
  assign done     = r_done;
  assign busy     = (r_state != S_IDLE);
  assign result   = r_result;
  assign mm_a     = r_mm_a;
  assign mm_b     = r_mm_b;
  assign mm_rst_n = r_mm_rst_n;
endmodule

// File: tb/tb_matmul_scheduler.sv
// Scheduler bench: behavioural fixed-latency multiplier, cycle-level job model, directed and random requests.
module tb_matmul_scheduler;
  import kalman_pkg::*;

  localparam int N    = 32;
  localparam int Q    = 18;
  localparam int NREQ = 4;
  localparam int LAT  = 18;
  localparam int MW   = MAT_W;
  localparam int SF   = 1 << Q;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*MW-1:0]   req_a = '0;
  logic [NREQ*MW-1:0]   req_b = '0;
  logic [NREQ-1:0]      grant, done;
  logic [MW-1:0]        result, mm_a, mm_b, mm_result;
  logic                 busy, mm_rst_n;

  int n_checks = 0;
  int n_errs   = 0;

  matmul_scheduler #(.N(N), .Q(Q), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
    .grant(grant), .done(done), .result(result), .busy(busy),
    .mm_a(mm_a), .mm_b(mm_b), .mm_rst_n(mm_rst_n), .mm_result(mm_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] matmul(input logic [511:0] a, input logic [511:0] b);
    logic [511:0] m;
    longint s;
    m = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        s = 0;
        for (int k = 0; k < 4; k++)
          s += longint'($signed(a[mat_idx(r, k)*32 +: 32])) * longint'($signed(b[mat_idx(k, c)*32 +: 32]));
        m[mat_idx(r, c)*32 +: 32] = 32'(s >>> Q);
      end
    return m;
  endfunction

  function automatic logic [511:0] rmat();
    logic [511:0] m;
    for (int e = 0; e < 16; e++)
      m[e*32 +: 32] = 32'(int'($urandom_range(0, 2097151)) - 1048576);
    return m;
  endfunction

  // Multiplier stand-in: product is only valid once it has run LAT cycles out of clear.
  int mm_c = 0;
  always @(posedge clk) mm_c <= mm_rst_n ? mm_c + 1 : 0;
  always_comb mm_result = (mm_c >= LAT - 1) ? matmul(mm_a, mm_b) : {16{32'hBAD0BAD0}};

  // Job-level reference: who should win, when done lands, what it carries.
  int              cyc = 0;
  bit              m_busy = 0;
  int              m_ptr = 0, m_owner = 0, m_t = 0;
  logic [511:0]    m_exp, m_a, m_b;
  logic [NREQ-1:0] last_grant = '0;
  logic [NREQ-1:0] exp_v;
  int              glog[$];
  int              tlog[$];
  int              gcnt[NREQ];
  int              dcnt = 0;

  always @(negedge clk) begin
    int k;
    cyc++;
    last_grant = grant;
    if (done != 0) dcnt++;
    for (int i = 0; i < NREQ; i++) if (grant[i]) gcnt[i]++;
    if (!reset) begin
      chk("grant_in_reset", grant, 0);
      m_busy = 0;
      m_ptr  = 0;
    end else if (!m_busy) begin
      k = -1;
      for (int i = 0; i < NREQ; i++)
        if (k < 0 && req[(m_ptr + i) % NREQ]) k = (m_ptr + i) % NREQ;
      exp_v = '0;
      if (k >= 0) exp_v[k] = 1'b1;
      chk("grant", grant, exp_v);
      chk("done_idle", done, 0);
      chk("busy_idle", busy, 0);
      chk("mm_rst_n_idle", mm_rst_n, 0);
      if (k >= 0) begin
        m_busy  = 1;
        m_owner = k;
        m_t     = cyc;
        m_a     = req_a[k*MW +: MW];
        m_b     = req_b[k*MW +: MW];
        m_exp   = matmul(m_a, m_b);
        m_ptr   = (k + 1) % NREQ;
        glog.push_back(k);
        tlog.push_back(cyc);
      end
    end else begin
      chk("grant_busy", grant, 0);
      chk("busy", busy, 1);
      if (cyc == m_t + 1) begin
        chk("mm_a_load", mm_a, m_a);
        chk("mm_b_load", mm_b, m_b);
      end
      chk("mm_rst_n", mm_rst_n, (cyc >= m_t + 2 && cyc <= m_t + LAT + 1) ? 1 : 0);
      exp_v = '0;
      if (cyc == m_t + LAT + 2) begin
        exp_v[m_owner] = 1'b1;
        chk("done", done, exp_v);
        chk("result", result, m_exp);
        m_busy = 0;
      end else begin
        chk("done_run", done, exp_v);
      end
    end
  end

  bit auto_clr = 1;

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_clr) req = req & ~last_grant;
  endtask

  task automatic set_req(input int k, input logic [511:0] a, input logic [511:0] b);
    req_a[k*MW +: MW] = a;
    req_b[k*MW +: MW] = b;
    req[k] = 1'b1;
  endtask

  task automatic wait_grant(input int k);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (last_grant[k]) return;
    end
    chk("wait_grant_timeout", 0, k + 1);
  endtask

  task automatic wait_done(input int k);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done[k]) return;
    end
    chk("wait_done_timeout", 0, k + 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!busy && req == 0) return;
    end
    chk("wait_idle_timeout", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [511:0] ma, mb, m5a, m5b;
    int n0, d0, g0;

    // Reset values
    reset = 0;
    repeat (3) tick();
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_mm_a", mm_a, 0);
    chk("rst_mm_b", mm_b, 0);
    chk("rst_mm_rst_n", mm_rst_n, 0);
    reset = 1;
    tick();

    // 1: identity times diagonal returns the diagonal
    ma = '0; mb = '0;
    for (int i = 0; i < 4; i++) ma[mat_idx(i, i)*32 +: 32] = SF;
    mb[mat_idx(0, 0)*32 +: 32] = SF;
    mb[mat_idx(1, 1)*32 +: 32] = 10 * SF;
    mb[mat_idx(2, 2)*32 +: 32] = 5 * SF;
    mb[mat_idx(3, 3)*32 +: 32] = 5 * SF;
    set_req(0, ma, mb);
    wait_done(0);
    chk("t1_result", result, mb);
    tick();

    // 2: all four held from reset release -> 0,1,2,3,0 spaced LAT+3
    auto_clr = 0;
    for (int k = 0; k < NREQ; k++) set_req(k, rmat(), rmat());
    reset = 0;
    tick();
    n0 = glog.size();
    reset = 1;
    for (int i = 0; i < 150 && glog.size() < n0 + 5; i++) tick();
    req = '0;
    auto_clr = 1;
    chk("t2_count", glog.size() >= n0 + 5, 1);
    if (glog.size() >= n0 + 5)
      for (int i = 0; i < 5; i++) begin
        chk("t2_order", glog[n0 + i], i % NREQ);
        if (i > 0) chk("t2_spacing", tlog[n0 + i] - tlog[n0 + i - 1], LAT + 3);
      end
    wait_idle();

    // 3: a request withdrawn before IDLE leaves no trace
    set_req(1, rmat(), rmat());
    wait_grant(1);
    g0 = gcnt[2];
    set_req(2, rmat(), rmat());
    repeat (5) tick();
    req[2] = 1'b0;
    wait_done(1);
    repeat (3) tick();
    chk("t3_no_grant2", gcnt[2] - g0, 0);

    // 4: reset during RUN (cnt=7) aborts without a done
    set_req(0, rmat(), rmat());
    wait_grant(0);
    repeat (8) tick();
    reset = 0;
    d0 = dcnt;
    tick();
    chk("t4_grant", grant, 0);
    chk("t4_done", done, 0);
    chk("t4_mm_rst_n", mm_rst_n, 0);
    chk("t4_result", result, 0);
    chk("t4_busy", busy, 0);
    reset = 1;
    repeat (30) tick();
    chk("t4_no_done", dcnt - d0, 0);

    // 5: saturating-free negative product, then result holds while idle
    for (int e = 0; e < 16; e++) begin
      m5a[e*32 +: 32] = 2 * SF;
      m5b[e*32 +: 32] = -(SF / 2);
    end
    set_req(3, m5a, m5b);
    wait_done(3);
    chk("t5_result", result, {16{32'hFFF00000}});
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t5_hold", result, {16{32'hFFF00000}});
    end

    // 6: owner re-requesting in DONE queues behind a pending requester
    set_req(1, rmat(), rmat());
    wait_grant(1);
    set_req(3, rmat(), rmat());
    wait_done(1);
    n0 = glog.size();
    set_req(1, rmat(), rmat());
    for (int i = 0; i < 100 && glog.size() < n0 + 2; i++) tick();
    chk("t6_count", glog.size() >= n0 + 2, 1);
    if (glog.size() >= n0 + 2) begin
      chk("t6_first", glog[n0], 3);
      chk("t6_second", glog[n0 + 1], 1);
    end
    wait_idle();

    // Random traffic against the job model
    for (int c = 0; c < 400; c++) begin
      tick();
      for (int k = 0; k < NREQ; k++)
        if (!req[k] && $urandom_range(0, 7) == 0) set_req(k, rmat(), rmat());
    end
    for (int i = 0; i < 400 && req != 0; i++) tick();
    wait_idle();
    chk("end_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
